// File: rtl/nios2_sram_ring_writer_pkg.sv
// Shared constants for the stream-to-SRAM ring writer: CSR map, CTRL/STATUS bits,
// reset geometry and default widths.
package nios2_sram_ring_writer_pkg;

  localparam int ADDR_W_DEF = 13;
  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] CSR_CTRL = 3'd0;
  localparam logic [2:0] CSR_BASE = 3'd1;
  localparam logic [2:0] CSR_SIZE = 3'd2;
  localparam logic [2:0] CSR_HEAD = 3'd3;
  localparam logic [2:0] CSR_TAIL = 3'd4;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CLEAR_BIT  = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;
  localparam int STAT_BUSY_BIT   = 3;
  localparam int STAT_FULL_BIT   = 4;

  localparam int SIZE_MIN   = 2;
  localparam int SIZE_RESET = 1 << ADDR_W_DEF;

endpackage

// File: rtl/nios2_sram_ring_writer_ptr_math.sv
// Combinational ring arithmetic: wrap-increment for the reserve and head pointers,
// and the modular fill level of the reserve pointer against the consumer tail.
module ring_ptr_math
  import nios2_sram_ring_writer_pkg::*;
#(
  parameter int AW = ADDR_W_DEF
) (
  input  logic [AW:0]   size_i,
  input  logic [AW-1:0] rsv_i,
  input  logic [AW-1:0] head_i,
  input  logic [AW-1:0] tail_i,
  output logic [AW-1:0] rsv_next_o,
  output logic [AW-1:0] head_next_o,
  output logic          full_o
);

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p, input logic [AW:0] sz);
    logic [AW:0] n;
    n = {1'b0, p} + (AW+1)'(1);
    return (n == sz) ? '0 : n[AW-1:0];
  endfunction

  logic [AW:0] rsv_w;
  logic [AW:0] tail_w;
  logic [AW:0] level;

  always_comb begin
    rsv_next_o  = wrap_inc(rsv_i, size_i);
    head_next_o = wrap_inc(head_i, size_i);
    rsv_w       = {1'b0, rsv_i};
    tail_w      = {1'b0, tail_i};
    level       = (rsv_w >= tail_w) ? (rsv_w - tail_w) : (rsv_w + size_i - tail_w);
    // One slot always stays empty so that head == tail unambiguously means empty.
    full_o      = (level == size_i - (AW+1)'(1));
  end

endmodule

// File: rtl/nios2_sram_ring_writer.sv
// Avalon-ST sink that writes each accepted word into a software-defined circular
// region of the dual-port SRAM (port 2) through a one-entry stage register.
module nios2_sram_ring_writer
  import nios2_sram_ring_writer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   sram_address,
  output logic                sram_chipselect,
  output logic                sram_write,
  output logic [DATA_W-1:0]   sram_writedata,
  output logic [DATA_W/8-1:0] sram_byteenable,
  output logic                sram_clken,
  input  logic [2:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata,
  output logic                irq
);

  localparam int SW = ADDR_W + 1;
  localparam logic [SW-1:0] SIZE_MAX = SW'(SIZE_RESET);

  // Stream handshake: a word transfers on a rising edge where in_valid and in_ready
  // are both high (ready-latency 0); in_ready never depends on in_valid.

  logic              en_q, en_d;
  logic              irq_en_q, irq_en_d;
  logic              clear_pending_q, clear_pending_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [SW-1:0]     size_q, size_d;
  logic [ADDR_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] rsv_q, rsv_d;
  logic [ADDR_W-1:0] tail_q, tail_d;
  logic              stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0] stage_addr_q, stage_addr_d;
  logic [DATA_W-1:0] stage_data_q, stage_data_d;
  logic [31:0]       readdata_q, readdata_d;

  logic [ADDR_W-1:0] rsv_next;
  logic [ADDR_W-1:0] head_next;
  logic              full;
  logic              ready_int;
  logic              accept;
  logic              cfg_locked;
  logic [31:0]       rd_mux;

  ring_ptr_math #(.AW(ADDR_W)) u_ptr_math (
    .size_i      (size_q),
    .rsv_i       (rsv_q),
    .head_i      (head_q),
    .tail_i      (tail_q),
    .rsv_next_o  (rsv_next),
    .head_next_o (head_next),
    .full_o      (full)
  );

  always_comb begin
    en_d            = en_q;
    irq_en_d        = irq_en_q;
    clear_pending_d = clear_pending_q;
    base_d          = base_q;
    size_d          = size_q;
    head_d          = head_q;
    rsv_d           = rsv_q;
    tail_d          = tail_q;
    stage_addr_d    = stage_addr_q;
    stage_data_d    = stage_data_q;

    ready_int  = en_q & ~full & ~clear_pending_q;
    accept     = in_valid & ready_int;
    cfg_locked = en_q | stage_valid_q;

    if (csr_write) begin
      case (csr_address)
        CSR_CTRL: begin
          en_d     = csr_writedata[CTRL_EN_BIT];
          irq_en_d = csr_writedata[CTRL_IRQ_EN_BIT];
          if (csr_writedata[CTRL_CLEAR_BIT]) clear_pending_d = 1'b1;
        end
        CSR_BASE: if (!cfg_locked) base_d = csr_writedata[ADDR_W-1:0];
        CSR_SIZE: begin
          if (!cfg_locked && csr_writedata >= 32'(SIZE_MIN) && csr_writedata <= 32'(SIZE_MAX))
            size_d = csr_writedata[SW-1:0];
        end
        CSR_TAIL: if (csr_writedata < 32'(size_q)) tail_d = csr_writedata[ADDR_W-1:0];
        default: ;
      endcase
    end

    // The stage always drains in the cycle after it fills, so it only holds a word
    // for the cycle following an accept.
    stage_valid_d = accept;
    if (accept) begin
      stage_addr_d = base_q + rsv_q;
      stage_data_d = in_data;
      rsv_d        = rsv_next;
    end
    if (stage_valid_q) head_d = head_next;

    if (clear_pending_q && !stage_valid_q) begin
      head_d          = '0;
      rsv_d           = '0;
      tail_d          = '0;
      clear_pending_d = 1'b0;
    end

    rd_mux = '0;
    case (csr_address)
      CSR_CTRL: begin
        rd_mux[CTRL_EN_BIT]     = en_q;
        rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
        rd_mux[STAT_BUSY_BIT]   = stage_valid_q;
        rd_mux[STAT_FULL_BIT]   = full;
      end
      CSR_BASE: rd_mux[ADDR_W-1:0] = base_q;
      CSR_SIZE: rd_mux[SW-1:0]     = size_q;
      CSR_HEAD: rd_mux[ADDR_W-1:0] = head_q;
      CSR_TAIL: rd_mux[ADDR_W-1:0] = tail_q;
      default: ;
    endcase
    readdata_d = csr_read ? rd_mux : readdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q            <= 1'b0;
      irq_en_q        <= 1'b0;
      clear_pending_q <= 1'b0;
      base_q          <= '0;
      size_q          <= SIZE_MAX;
      head_q          <= '0;
      rsv_q           <= '0;
      tail_q          <= '0;
      stage_valid_q   <= 1'b0;
      stage_addr_q    <= '0;
      stage_data_q    <= '0;
      readdata_q      <= '0;
    end else begin
      en_q            <= en_d;
      irq_en_q        <= irq_en_d;
      clear_pending_q <= clear_pending_d;
      base_q          <= base_d;
      size_q          <= size_d;
      head_q          <= head_d;
      rsv_q           <= rsv_d;
      tail_q          <= tail_d;
      stage_valid_q   <= stage_valid_d;
      stage_addr_q    <= stage_addr_d;
      stage_data_q    <= stage_data_d;
      readdata_q      <= readdata_d;
    end
  end

  // Gating with reset keeps a staged word off the SRAM in the cycle reset is applied.
  assign in_ready        = ready_int & ~reset;
  assign sram_chipselect = stage_valid_q & ~reset;
  assign sram_write      = stage_valid_q & ~reset;
  assign sram_address    = stage_addr_q;
  assign sram_writedata  = stage_data_q;
  assign sram_byteenable = '1;
  assign sram_clken      = 1'b1;
  assign csr_readdata    = readdata_q;
  assign irq             = irq_en_q & (head_q != tail_q);

endmodule

// File: tb/tb_nios2_sram_ring_writer.sv
// Self-checking bench for nios2_sram_ring_writer: CSR vector table plus directed
// fill, backpressure, wrap, disable, clear and reset sequences.
module tb_nios2_sram_ring_writer;
  import nios2_sram_ring_writer_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] sram_address;
  logic          sram_chipselect;
  logic          sram_write;
  logic [DW-1:0] sram_writedata;
  logic [3:0]    sram_byteenable;
  logic          sram_clken;
  logic [2:0]    csr_address;
  logic          csr_read;
  logic          csr_write;
  logic [31:0]   csr_writedata;
  logic [31:0]   csr_readdata;
  logic          irq;

  nios2_sram_ring_writer dut (
    .clk             (clk),
    .reset           (reset),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_writedata  (sram_writedata),
    .sram_byteenable (sram_byteenable),
    .sram_clken      (sram_clken),
    .csr_address     (csr_address),
    .csr_read        (csr_read),
    .csr_write       (csr_write),
    .csr_writedata   (csr_writedata),
    .csr_readdata    (csr_readdata),
    .irq             (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];
  int wr_cyc_q[$];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // scoreboard: every SRAM write must match the oldest expected {addr, data}
  always @(negedge clk) begin : sram_mon
    logic [AW+DW-1:0] e;
    #2;
    if (sram_chipselect === 1'b1 || sram_write === 1'b1) begin
      wr_cyc_q.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h required no write",
                 sram_address, sram_writedata);
      end else begin
        e = exp_q.pop_front();
        if ({sram_address, sram_writedata} !== e || sram_chipselect !== sram_write) begin
          errors++;
          $display("FAIL sram_write: got cs %0b wr %0b addr 0x%0h data 0x%0h required addr 0x%0h data 0x%0h",
                   sram_chipselect, sram_write, sram_address, sram_writedata, e[AW+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  // driver tasks (called at or just after a falling edge)
  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address   = a;
    csr_writedata = d;
    csr_write     = 1'b1;
    @(negedge clk);
    csr_write     = 1'b0;
  endtask

  task automatic csr_rd(input logic [2:0] a, output logic [31:0] d);
    csr_address = a;
    csr_read    = 1'b1;
    @(negedge clk);
    csr_read    = 1'b0;
    d           = csr_readdata;
  endtask

  task automatic csr_chk(input string name, input logic [2:0] a, input logic [31:0] req);
    logic [31:0] d;
    csr_rd(a, d);
    check(name, d, req);
  endtask

  task automatic send(input logic [31:0] data, input logic [AW-1:0] exp_addr);
    int waited;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = data;
    while (in_ready !== 1'b1) begin
      @(negedge clk);
      waited++;
      if (waited > 50) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: data 0x%0h never accepted, required accept", data);
        in_valid = 1'b0;
        return;
      end
    end
    exp_q.push_back({exp_addr, data});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic expect_stall(input string name, input logic [31:0] data, input int n);
    in_valid = 1'b1;
    in_data  = data;
    for (int i = 0; i < n; i++) begin
      #1;
      check(name, {31'b0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } cfg_vec_t;

  cfg_vec_t cfg_tbl [17];

  initial begin : main
    logic [31:0] d;

    cfg_tbl[0]  = '{CSR_SIZE, 1'b1, 32'd1,          32'd8192};
    cfg_tbl[1]  = '{CSR_SIZE, 1'b1, 32'd8193,       32'd8192};
    cfg_tbl[2]  = '{CSR_SIZE, 1'b1, 32'd2,          32'd2};
    cfg_tbl[3]  = '{CSR_SIZE, 1'b1, 32'd8192,       32'd8192};
    cfg_tbl[4]  = '{CSR_BASE, 1'b1, 32'hFFFF_F123,  32'h1123};
    cfg_tbl[5]  = '{CSR_TAIL, 1'b1, 32'd8192,       32'd0};
    cfg_tbl[6]  = '{CSR_TAIL, 1'b1, 32'd5,          32'd5};
    cfg_tbl[7]  = '{CSR_TAIL, 1'b1, 32'd0,          32'd0};
    cfg_tbl[8]  = '{3'd5,     1'b1, 32'hDEAD,       32'd0};
    cfg_tbl[9]  = '{3'd7,     1'b0, 32'd0,          32'd0};
    cfg_tbl[10] = '{CSR_CTRL, 1'b1, 32'h4,          32'h4};
    cfg_tbl[11] = '{CSR_CTRL, 1'b1, 32'h0,          32'h0};
    cfg_tbl[12] = '{CSR_HEAD, 1'b1, 32'd7,          32'd0};
    cfg_tbl[13] = '{CSR_CTRL, 1'b1, 32'h1,          32'h1};
    cfg_tbl[14] = '{CSR_BASE, 1'b1, 32'h55,         32'h1123};
    cfg_tbl[15] = '{CSR_SIZE, 1'b1, 32'd16,         32'd8192};
    cfg_tbl[16] = '{CSR_CTRL, 1'b1, 32'h0,          32'h0};

    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    csr_address = '0;
    csr_read = 1'b0;
    csr_write = 1'b0;
    csr_writedata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;

    // reset state
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_cs", {31'b0, sram_chipselect}, 32'd0);
    check("rst_write", {31'b0, sram_write}, 32'd0);
    check("rst_addr", 32'(sram_address), 32'd0);
    check("rst_wdata", sram_writedata, 32'd0);
    check("rst_rdata", csr_readdata, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    check("byteenable", {28'b0, sram_byteenable}, 32'hF);
    check("clken", {31'b0, sram_clken}, 32'd1);
    csr_chk("rst_ctrl", CSR_CTRL, 32'd0);
    csr_chk("rst_size", CSR_SIZE, 32'd8192);
    csr_chk("rst_head", CSR_HEAD, 32'd0);

    // CSR vector table
    for (int i = 0; i < 17; i++) begin
      if (cfg_tbl[i].wr) csr_wr(cfg_tbl[i].addr, cfg_tbl[i].wdata);
      csr_rd(cfg_tbl[i].addr, d);
      check($sformatf("cfg_vec_%0d", i), d, cfg_tbl[i].exp);
    end

    // basic fill
    csr_wr(CSR_BASE, 32'h100);
    csr_wr(CSR_SIZE, 32'd8);
    csr_wr(CSR_CTRL, 32'h5);
    wr_cyc_q.delete();
    send(32'hA0, 13'h100);
    send(32'hA1, 13'h101);
    send(32'hA2, 13'h102);
    @(negedge clk);
    check("fill_nwrites", wr_cyc_q.size(), 32'd3);
    if (wr_cyc_q.size() == 3) begin
      check("fill_b2b_1", wr_cyc_q[1] - wr_cyc_q[0], 32'd1);
      check("fill_b2b_2", wr_cyc_q[2] - wr_cyc_q[1], 32'd1);
    end
    csr_chk("fill_head", CSR_HEAD, 32'd3);
    check("fill_irq", {31'b0, irq}, 32'd1);
    csr_chk("fill_ctrl", CSR_CTRL, 32'h5);

    // full / backpressure
    csr_wr(CSR_CTRL, 32'h2);
    csr_wr(CSR_SIZE, 32'd4);
    csr_wr(CSR_BASE, 32'h200);
    csr_wr(CSR_CTRL, 32'h1);
    csr_chk("clr_head", CSR_HEAD, 32'd0);
    send(32'hB0, 13'h200);
    send(32'hB1, 13'h201);
    send(32'hB2, 13'h202);
    expect_stall("full_stall", 32'hB3, 3);
    csr_chk("full_ctrl", CSR_CTRL, 32'h11);
    csr_wr(CSR_TAIL, 32'd2);
    send(32'hB3, 13'h203);
    send(32'hB4, 13'h200);
    #1;
    check("refull_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    csr_chk("refull_head", CSR_HEAD, 32'd1);

    // address wrap across the top of the SRAM
    csr_wr(CSR_CTRL, 32'h2);
    csr_wr(CSR_BASE, 32'h1FFE);
    csr_wr(CSR_SIZE, 32'd4);
    csr_wr(CSR_CTRL, 32'h1);
    send(32'hC0, 13'h1FFE);
    send(32'hC1, 13'h1FFF);
    csr_wr(CSR_TAIL, 32'd2);
    send(32'hC2, 13'h0000);
    send(32'hC3, 13'h0001);
    @(negedge clk);

    // disable with a staged word
    send(32'hD0, 13'h1FFE);
    #1;
    check("dis_stage_cs", {31'b0, sram_chipselect}, 32'd1);
    check("dis_stage_addr", 32'(sram_address), 32'h1FFE);
    csr_wr(CSR_CTRL, 32'h0);
    expect_stall("dis_stall", 32'hD1, 3);
    csr_chk("dis_head", CSR_HEAD, 32'd1);

    // clear while streaming
    csr_wr(CSR_TAIL, 32'd1);
    csr_wr(CSR_CTRL, 32'h5);
    in_valid = 1'b1;
    in_data  = 32'hE0;
    check("clr_ready0", {31'b0, in_ready}, 32'd1);
    exp_q.push_back({13'h1FFF, 32'hE0});
    csr_wr(CSR_CTRL, 32'h7);
    in_data = 32'hE1;
    #1;
    check("clr_block1", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("clr_block2", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    check("clr_resume", {31'b0, in_ready}, 32'd1);
    check("clr_irq", {31'b0, irq}, 32'd0);
    exp_q.push_back({13'h1FFE, 32'hE1});
    csr_rd(CSR_HEAD, d);
    in_valid = 1'b0;
    check("clr_head", d, 32'd0);
    csr_chk("clr_tail", CSR_TAIL, 32'd0);
    check("clr_irq_after", {31'b0, irq}, 32'd1);

    // reset with a staged write
    in_valid = 1'b1;
    in_data  = 32'hF0;
    check("rmw_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    check("rmw_cs", {31'b0, sram_chipselect}, 32'd0);
    check("rmw_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rmw_cs_after", {31'b0, sram_chipselect}, 32'd0);
    check("rmw_irq", {31'b0, irq}, 32'd0);
    csr_chk("rmw_ctrl", CSR_CTRL, 32'd0);
    csr_chk("rmw_size", CSR_SIZE, 32'd8192);
    csr_chk("rmw_head", CSR_HEAD, 32'd0);
    csr_chk("rmw_tail", CSR_TAIL, 32'd0);
    csr_wr(CSR_BASE, 32'h42);
    csr_chk("rmw_base_wr", CSR_BASE, 32'h42);
    csr_wr(CSR_SIZE, 32'd16);
    csr_chk("rmw_size_wr", CSR_SIZE, 32'd16);

    repeat (4) @(negedge clk);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nios2_sram_ring_writer.md
# nios2_sram_ring_writer

Avalon-ST to SRAM ring-buffer writer that sits directly upstream of the second Nios II core's dual-port on-chip SRAM. It drives the SRAM's second port (s2) as a write-only master. Incoming 32-bit stream words (sensor/lidar samples) land in a software-configured circular region, and the core drains that region through port s1. A small CSR slave exposes base, size, head and tail pointers plus an interrupt.

## Interface
- `ADDR_W`, 13: SRAM word-address width (8192 words).
- `DATA_W`, 32: stream and SRAM data width.
- `clk` in 1: single clock, shared with the SRAM.
- `reset` in 1: synchronous, active-high.
- `in_data` in 32: stream word.
- `in_valid` in 1: stream word valid.
- `in_ready` out 1: stream ready, ready-latency 0.
- `sram_address` out 13: to SRAM `address2`.
- `sram_chipselect` out 1: to `chipselect2`.
- `sram_write` out 1: to `write2`.
- `sram_writedata` out 32: to `writedata2`.
- `sram_byteenable` out 4: to `byteenable2`; constant 4'hF.
- `sram_clken` out 1: to `clken2`; constant 1.
- `csr_address` in 3: CSR word index.
- `csr_read` in 1: CSR read strobe.
- `csr_write` in 1: CSR write strobe.
- `csr_writedata` in 32: CSR write data.
- `csr_readdata` out 32: CSR read data, 1-cycle read latency.
- `irq` out 1: level interrupt.

## Operation
- CSR map:
  - 0 CTRL: bit0 EN, bit1 CLEAR (write-1, self-clearing), bit2 IRQ_EN. Read returns {FULL bit4, BUSY bit3, IRQ_EN, 0, EN}.
  - 1 BASE: bits[12:0].
  - 2 SIZE: bits[13:0], valid range 2..8192.
  - 3 HEAD: read-only, committed write offset.
  - 4 TAIL: RW, consumer offset written by software.
  - 5–7: read 0, writes ignored.
- Writes to BASE/SIZE are ignored while EN=1 or BUSY=1. SIZE writes outside 2..8192 are ignored. TAIL writes ≥ SIZE are ignored.
- Pointers:
  - `rsv` (reserve) advances on stream accept.
  - `head` advances when the SRAM write is issued.
  - Both wrap to 0 at SIZE−1+1.
- `level = rsv − tail` (mod SIZE; `rsv ≥ tail ? rsv−tail : rsv+SIZE−tail`). FULL when level == SIZE−1; one slot is always kept empty.
- `in_ready = EN & ~FULL & ~clear_pending & ~reset`.
- Accept (in_valid & in_ready):
  - Capture the data and address `(BASE + rsv) mod 2^13` into a one-entry stage register.
  - The next cycle asserts chipselect=write=1 with the staged values and advances head.
  - BUSY means the stage register is occupied.
- Back-to-back accepts give one SRAM write per cycle.
- A disable (EN 1→0) with the stage occupied still completes the staged write.
- CLEAR sets `clear_pending`, which blocks accepts. Once the stage is empty, head=rsv=tail=0 and `clear_pending` drops.
- `irq = IRQ_EN & (head != tail)`.
- If a TAIL write and an accept occur in the same cycle, both take effect and FULL is computed from the new values the next cycle.

## Timing
- Reset values:
  - Registers: EN=0, IRQ_EN=0, BASE=0, SIZE=8192, head=rsv=tail=0, stage empty.
  - Outputs: in_ready=0, chipselect=write=0, address=0, writedata=0, csr_readdata=0, irq=0.
- Latency: stream accept at edge N drives the SRAM write during cycle N+1, committed at edge N+1. HEAD reads reflect it from N+2.
- Sustained throughput: 1 word/clk until FULL.
- CSR read data is valid the cycle after `csr_read`, and held otherwise.
- Reset mid-write drops the staged word; no SRAM write is issued after reset asserts.

## Structure
- The shared package holds: CSR index constants, CTRL/STATUS bit positions, the `SIZE` reset constant, and `ADDR_W`/`DATA_W` defaults.
- One sub-module, `ring_ptr_math`: combinational wrap-increment and modular level/full computation, reused for `rsv` and `head`.

## Test plan
- **Basic fill:** BASE=0x100, SIZE=8, EN=1; stream 3 words 0xA0..0xA2 -> SRAM writes at 0x100..0x102 on consecutive cycles, HEAD=3, irq=1 with IRQ_EN set.
- **Full/backpressure:** SIZE=4, tail=0; stream 5 words -> 3 accepted, in_ready=0 thereafter, FULL=1. Write TAIL=2 -> 2 more accepted, at addresses BASE+3 and BASE+0 (wrap).
- **Address wrap:** BASE=0x1FFE, SIZE=4; stream 4 words with tail advancing -> addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- **Disable mid-stream:** EN←0 in the cycle after an accept -> the staged write still issues, and no further accepts.
- **Clear:** CLEAR while streaming -> at most one more SRAM write, then HEAD=TAIL=0, irq=0, accepts resume the next cycle if EN=1.
- **Reset mid-write:** assert `reset` in the cycle a staged write is pending -> chipselect=0 that cycle, all registers return to reset values, and BASE/SIZE writes are accepted again.
